// File: rtl/breakout_game_ctrl.sv
// Breakout game-control FSM: sequences start, ball relaunch, level clear and game over,
// and keeps lives, level, bricks remaining and a saturating BCD score for the display.
module breakout_game_ctrl #(
    parameter int LIVES          = 3,
    parameter int SCORE_DIGITS   = 4,
    parameter int BRICK_COUNT    = 48,
    parameter int MAX_LEVEL      = 9,
    parameter int NEWBALL_FRAMES = 60,
    parameter int OVER_FRAMES    = 180
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      frame_tick,
    input  logic                      start,
    input  logic                      brick_hit,
    input  logic                      paddle_hit,
    input  logic                      miss,
    output logic [2:0]                state,
    output logic                      gra_still,
    output logic                      ball_reset,
    output logic                      brick_reload,
    output logic [4*SCORE_DIGITS-1:0] score,
    output logic [3:0]                lives,
    output logic [3:0]                level,
    output logic [7:0]                bricks_left
);
    // state   | meaning
    // IDLE    | waiting for start, last score still displayed
    // PLAY    | ball in motion, hit/miss events counted
    // NEWBALL | frozen for a number of frames before (re)launch
    // LEVELUP | level cleared, reload on the next frame
    // OVER    | game finished, final score shown for a number of frames
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PLAY    = 3'd1,
        S_NEWBALL = 3'd2,
        S_LEVELUP = 3'd3,
        S_OVER    = 3'd4
    } state_t;

    localparam logic [3:0] LIVES_INIT  = 4'(LIVES);
    localparam logic [3:0] LEVEL_LAST  = 4'(MAX_LEVEL);
    localparam logic [7:0] BRICKS_INIT = 8'(BRICK_COUNT);
    localparam logic [7:0] NB_LAST     = 8'(NEWBALL_FRAMES - 1);
    localparam logic [7:0] OVER_LAST   = 8'(OVER_FRAMES - 1);

    state_t                    state_q, state_d;
    logic [7:0]                timer_q, timer_d;
    logic                      start_q, start_arm;
    logic                      start_rise, new_game, carry;
    logic [4*SCORE_DIGITS-1:0] score_d, score_inc;
    logic [3:0]                lives_d, level_d;
    logic [7:0]                bricks_d;
    logic                      ball_reset_d, brick_reload_d;

    // start_arm stays low until start has been seen low, so a key held through reset is not an edge
    assign start_rise = start & ~start_q & start_arm;
    assign new_game   = start_rise && (state_q == S_IDLE || state_q == S_OVER);
    assign state      = state_q;
    assign gra_still  = (state_q != S_PLAY);

    always_comb begin
        score_inc = score;
        carry     = 1'b1;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            if (carry) begin
                if (score[4*i +: 4] == 4'd9) begin
                    score_inc[4*i +: 4] = 4'd0;
                end else begin
                    score_inc[4*i +: 4] = score[4*i +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
        if (carry) score_inc = score;   // all digits 9: hold instead of wrapping
    end

    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        score_d        = score;
        lives_d        = lives;
        level_d        = level;
        bricks_d       = bricks_left;
        ball_reset_d   = 1'b0;
        brick_reload_d = 1'b0;
        case (state_q)
            S_IDLE: ;
            S_NEWBALL: begin
                if (frame_tick) begin
                    if (timer_q == NB_LAST) begin
                        state_d = S_PLAY;
                        timer_d = 8'd0;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
            end
            S_PLAY: begin
                // paddle_hit is reserved and has no effect of its own
                if (brick_hit || miss || paddle_hit) begin
                    if (brick_hit) begin
                        score_d  = score_inc;
                        bricks_d = bricks_left - 8'd1;
                    end
                    if (brick_hit && bricks_left == 8'd1) begin
                        timer_d = 8'd0;
                        state_d = (level == LEVEL_LAST) ? S_OVER : S_LEVELUP;
                    end else if (miss) begin
                        timer_d = 8'd0;
                        if (lives == 4'd1) begin
                            lives_d = 4'd0;
                            state_d = S_OVER;
                        end else begin
                            lives_d      = lives - 4'd1;
                            ball_reset_d = 1'b1;
                            state_d      = S_NEWBALL;
                        end
                    end
                end
            end
            S_LEVELUP: begin
                if (frame_tick) begin
                    level_d        = level + 4'd1;
                    bricks_d       = BRICKS_INIT;
                    brick_reload_d = 1'b1;
                    ball_reset_d   = 1'b1;
                    state_d        = S_NEWBALL;
                    timer_d        = 8'd0;
                end
            end
            S_OVER: begin
                if (frame_tick) begin
                    if (timer_q == OVER_LAST) begin
                        state_d = S_IDLE;
                        timer_d = 8'd0;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = 8'd0;
            end
        endcase
        if (new_game) begin
            score_d        = '0;
            lives_d        = LIVES_INIT;
            level_d        = 4'd1;
            bricks_d       = BRICKS_INIT;
            brick_reload_d = 1'b1;
            ball_reset_d   = 1'b1;
            state_d        = S_NEWBALL;
            timer_d        = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            timer_q      <= 8'd0;
            start_q      <= 1'b0;
            start_arm    <= 1'b0;
            score        <= '0;
            lives        <= LIVES_INIT;
            level        <= 4'd1;
            bricks_left  <= BRICKS_INIT;
            ball_reset   <= 1'b0;
            brick_reload <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            start_q      <= start;
            start_arm    <= start_arm | ~start;
            score        <= score_d;
            lives        <= lives_d;
            level        <= level_d;
            bricks_left  <= bricks_d;
            ball_reset   <= ball_reset_d;
            brick_reload <= brick_reload_d;
        end
    end
endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Scoreboard bench for breakout_game_ctrl: three parameterisations share one stimulus bus,
// each phase checks one of them against hand-derived expectations.
module tb_breakout_game_ctrl;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic frame_tick = 1'b0, start = 1'b0, brick_hit = 1'b0, paddle_hit = 1'b0, miss = 1'b0;

    always #5 clk = ~clk;

    logic [2:0]  st_a, st_b, st_c;
    logic        gs_a, gs_b, gs_c, br_a, br_b, br_c, rl_a, rl_b, rl_c;
    logic [15:0] sc_a, sc_b;
    logic [7:0]  sc_c;
    logic [3:0]  lv_a, lv_b, lv_c, lev_a, lev_b, lev_c;
    logic [7:0]  bl_a, bl_b, bl_c;

    breakout_game_ctrl dut_a (
        .clk(clk), .rstn(rstn), .frame_tick(frame_tick), .start(start), .brick_hit(brick_hit),
        .paddle_hit(paddle_hit), .miss(miss), .state(st_a), .gra_still(gs_a), .ball_reset(br_a),
        .brick_reload(rl_a), .score(sc_a), .lives(lv_a), .level(lev_a), .bricks_left(bl_a));

    breakout_game_ctrl #(.BRICK_COUNT(2), .MAX_LEVEL(2)) dut_b (
        .clk(clk), .rstn(rstn), .frame_tick(frame_tick), .start(start), .brick_hit(brick_hit),
        .paddle_hit(paddle_hit), .miss(miss), .state(st_b), .gra_still(gs_b), .ball_reset(br_b),
        .brick_reload(rl_b), .score(sc_b), .lives(lv_b), .level(lev_b), .bricks_left(bl_b));

    breakout_game_ctrl #(.SCORE_DIGITS(2), .BRICK_COUNT(103), .MAX_LEVEL(1),
                         .NEWBALL_FRAMES(1), .OVER_FRAMES(2)) dut_c (
        .clk(clk), .rstn(rstn), .frame_tick(frame_tick), .start(start), .brick_hit(brick_hit),
        .paddle_hit(paddle_hit), .miss(miss), .state(st_c), .gra_still(gs_c), .ball_reset(br_c),
        .brick_reload(rl_c), .score(sc_c), .lives(lv_c), .level(lev_c), .bricks_left(bl_c));

    typedef struct {
        int          id;
        int          tag;
        logic [2:0]  st;
        logic        br;
        logic        rl;
        logic [31:0] sc;
        logic [3:0]  lv;
        logic [3:0]  lev;
        logic [7:0]  bl;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   tag = 0;

    int          e_id;
    logic [2:0]  e_st;
    logic        e_br, e_rl;
    logic [31:0] e_sc;
    logic [3:0]  e_lv, e_lev;
    logic [7:0]  e_bl;

    function automatic exp_t snap();
        exp_t e;
        e.id = e_id; e.tag = tag; e.st = e_st; e.br = e_br; e.rl = e_rl;
        e.sc = e_sc; e.lv = e_lv; e.lev = e_lev; e.bl = e_bl;
        return e;
    endfunction

    function automatic logic [31:0] bcd(input int n);
        return 32'(((n / 10) % 10) * 16 + (n % 10));
    endfunction

    task automatic chk(input int t, input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL chk%0d %s actual=%0h required=%0h", t, nm, act, req);
        end
    endtask

    task automatic compare(input exp_t e);
        logic [2:0]  st;
        logic        gs, br, rl;
        logic [31:0] sc;
        logic [3:0]  lv, lev;
        logic [7:0]  bl;
        case (e.id)
            0: begin st = st_a; gs = gs_a; br = br_a; rl = rl_a; sc = {16'd0, sc_a};
                     lv = lv_a; lev = lev_a; bl = bl_a; end
            1: begin st = st_b; gs = gs_b; br = br_b; rl = rl_b; sc = {16'd0, sc_b};
                     lv = lv_b; lev = lev_b; bl = bl_b; end
            default: begin st = st_c; gs = gs_c; br = br_c; rl = rl_c; sc = {24'd0, sc_c};
                     lv = lv_c; lev = lev_c; bl = bl_c; end
        endcase
        chk(e.tag, "state", st, e.st);
        chk(e.tag, "gra_still", gs, (e.st != 3'd1));
        chk(e.tag, "ball_reset", br, e.br);
        chk(e.tag, "brick_reload", rl, e.rl);
        chk(e.tag, "score", sc, e.sc);
        chk(e.tag, "lives", lv, e.lv);
        chk(e.tag, "level", lev, e.lev);
        chk(e.tag, "bricks_left", bl, e.bl);
    endtask

    // monitor: outputs updated by the posedge are compared just after it
    initial begin
        exp_t m;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                m = q.pop_front();
                compare(m);
            end
        end
    end

    task automatic cyc(input logic ft, input logic st, input logic bh, input logic ph,
                       input logic ms, input bit check);
        @(negedge clk);
        frame_tick = ft; start = st; brick_hit = bh; paddle_hit = ph; miss = ms;
        if (check) begin
            tag++;
            q.push_back(snap());
        end
        e_br = 1'b0;
        e_rl = 1'b0;
    endtask

    task automatic frames(input int n, input logic [2:0] final_st);
        for (int i = 1; i < n; i++) cyc(1, 0, 0, 0, 0, 1);
        e_st = final_st;
        cyc(1, 0, 0, 0, 0, 1);
    endtask

    task automatic defaults(input int id, input logic [7:0] bricks);
        e_id = id; e_st = 3'd0; e_br = 1'b0; e_rl = 1'b0; e_sc = 32'd0;
        e_lv = 4'd3; e_lev = 4'd1; e_bl = bricks;
    endtask

    task automatic do_reset(input int id, input logic [7:0] bricks, input logic st_lvl);
        @(negedge clk);
        rstn = 1'b0; start = st_lvl;
        frame_tick = 1'b0; brick_hit = 1'b0; paddle_hit = 1'b0; miss = 1'b0;
        #1;
        defaults(id, bricks);
        tag++;
        compare(snap());
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---- phase A: default parameters ----
        do_reset(0, 8'd48, 1'b0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 1);                        // brick_hit ignored in IDLE
        e_st = 3'd2; e_br = 1'b1; e_rl = 1'b1;
        cyc(0, 1, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 1);                        // brick_hit ignored in NEWBALL
        frames(60, 3'd1);
        for (int i = 1; i <= 12; i++) begin
            e_sc = bcd(i); e_bl = 8'(48 - i);
            cyc(0, 0, 1, 0, 0, 1);
        end
        cyc(0, 0, 0, 1, 0, 1);                        // paddle_hit: no change
        e_sc = 32'h13; e_bl = 8'd35; e_lv = 4'd2; e_br = 1'b1; e_st = 3'd2;
        cyc(0, 0, 1, 0, 1, 1);                        // hit + miss together
        frames(60, 3'd1);
        e_lv = 4'd1; e_br = 1'b1; e_st = 3'd2;
        cyc(0, 0, 0, 0, 1, 1);
        frames(60, 3'd1);
        e_lv = 4'd0; e_st = 3'd4;
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 1, 0, 0, 1);                        // ignored in OVER
        frames(180, 3'd0);
        cyc(0, 0, 0, 0, 0, 1);
        e_st = 3'd2; e_sc = 32'd0; e_lv = 4'd3; e_lev = 4'd1; e_bl = 8'd48;
        e_br = 1'b1; e_rl = 1'b1;
        cyc(0, 1, 0, 0, 0, 1);
        frames(60, 3'd1);
        for (int i = 1; i <= 25; i++) begin
            e_sc = bcd(i); e_bl = 8'(48 - i);
            cyc(0, 0, 1, 0, 0, 1);
        end
        do_reset(0, 8'd48, 1'b1);                     // mid-PLAY reset, start held high
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        e_st = 3'd2; e_br = 1'b1; e_rl = 1'b1;
        cyc(0, 1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);

        // ---- phase B: BRICK_COUNT=2, MAX_LEVEL=2 ----
        do_reset(1, 8'd2, 1'b0);
        e_st = 3'd2; e_br = 1'b1; e_rl = 1'b1;
        cyc(0, 1, 0, 0, 0, 1);
        frames(60, 3'd1);
        e_sc = 32'd1; e_bl = 8'd1;
        cyc(0, 0, 1, 0, 0, 1);
        e_sc = 32'd2; e_bl = 8'd0; e_st = 3'd3;
        cyc(0, 0, 1, 0, 1, 1);                        // last brick wins over miss
        cyc(0, 0, 1, 0, 0, 1);                        // ignored in LEVELUP
        e_lev = 4'd2; e_bl = 8'd2; e_br = 1'b1; e_rl = 1'b1; e_st = 3'd2;
        cyc(1, 0, 0, 0, 0, 1);
        frames(60, 3'd1);
        e_sc = 32'd3; e_bl = 8'd1;
        cyc(0, 0, 1, 0, 0, 1);
        e_sc = 32'd4; e_bl = 8'd0; e_st = 3'd4;
        cyc(0, 0, 1, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 1);
        e_st = 3'd2; e_sc = 32'd0; e_lv = 4'd3; e_lev = 4'd1; e_bl = 8'd2;
        e_br = 1'b1; e_rl = 1'b1;
        cyc(0, 1, 0, 0, 0, 1);                        // start in OVER: new game
        cyc(0, 0, 0, 0, 0, 1);

        // ---- phase C: 2 digits, 103 bricks, MAX_LEVEL=1, short timers ----
        do_reset(2, 8'd103, 1'b0);
        e_st = 3'd2; e_br = 1'b1; e_rl = 1'b1;
        cyc(0, 1, 0, 0, 0, 1);
        frames(1, 3'd1);
        for (int i = 1; i <= 101; i++) begin
            e_sc = (i > 99) ? 32'h99 : bcd(i); e_bl = 8'(103 - i);
            cyc(0, 0, 1, 0, 0, 1);
        end
        e_bl = 8'd1;
        cyc(0, 0, 1, 0, 0, 1);
        e_bl = 8'd0; e_st = 3'd4;
        cyc(0, 0, 1, 0, 0, 1);
        frames(2, 3'd0);

        cyc(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk(tag, "queue_drain", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
